// File: rtl/riscv_test_pkg.sv
// Shared types and constants for the riscv-tests tohost end-of-test monitor.
package riscv_test_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } status_e;

    localparam int unsigned TOHOST_PASS = 1;

endpackage

// File: rtl/riscv_test_chan.sv
// One monitored core: tohost decode FSM, failing test number and, with
// RISCV_TEST_MONITOR_RETIRE_EN, a retired-instruction counter.
module riscv_test_chan
    import riscv_test_pkg::*;
#(
    parameter int unsigned          ADDR_W      = 16,
    parameter int unsigned          XLEN        = 32,
    parameter logic [ADDR_W-1:0]    TOHOST_ADDR = 16'h1000,
    parameter int unsigned          CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                timeout,
`ifdef RISCV_TEST_MONITOR_RETIRE_EN
    input  logic                retire,
    output logic [CNT_W-1:0]    retired,
`endif
    output status_e             status,
    output logic [XLEN-2:0]     fail_num
);

    status_e           state_q, state_d;
    logic [XLEN-2:0]   fail_q, fail_d;
    logic              hit;

    assign hit = wr_en && (wr_addr == TOHOST_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
        end
    end

    // An even tohost value is a syscall/console write and must not block the watchdog.
    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        if (state_q == ST_RUN) begin
            if (hit && wr_data[0]) begin
                if (wr_data == XLEN'(TOHOST_PASS)) begin
                    state_d = ST_PASS;
                end else begin
                    state_d = ST_FAIL;
                    fail_d  = wr_data[XLEN-1:1];
                end
            end else if (timeout) begin
                state_d = ST_TIMEOUT;
            end
        end
    end

    assign status   = state_q;
    assign fail_num = fail_q;

`ifdef RISCV_TEST_MONITOR_RETIRE_EN
    logic [CNT_W-1:0] ret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ret_q <= '0;
        end else if (state_q == ST_RUN && retire && ret_q != '1) begin
            ret_q <= ret_q + CNT_W'(1);
        end
    end

    assign retired = ret_q;
`endif

endmodule

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor: per-core tohost decode, shared cycle counter and watchdog.
// Define RISCV_TEST_MONITOR_RETIRE_EN to add per-channel retired-instruction counts.
module riscv_test_monitor
    import riscv_test_pkg::*;
#(
    parameter int unsigned          NCH         = 1,
    parameter int unsigned          ADDR_W      = 16,
    parameter int unsigned          XLEN        = 32,
    parameter logic [ADDR_W-1:0]    TOHOST_ADDR = 16'h1000,
    parameter int unsigned          TIMEOUT     = 5000,
    parameter int unsigned          CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          wr_en,
    input  logic [NCH*ADDR_W-1:0]   wr_addr,
    input  logic [NCH*XLEN-1:0]     wr_data,
    input  logic [NCH-1:0]          retire,
    output logic [NCH*2-1:0]        status,
    output logic [NCH*(XLEN-1)-1:0] fail_num,
    output logic                    done,
    output logic                    all_pass,
    output logic [CNT_W-1:0]        cycles
`ifdef RISCV_TEST_MONITOR_RETIRE_EN
   ,output logic [NCH*CNT_W-1:0]    retired
`endif
);

    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             timeout;
    status_e          chan_st [NCH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    always_comb begin
        cycles_d = cycles_q;
        if (!done && cycles_q != '1) begin
            cycles_d = cycles_q + CNT_W'(1);
        end
    end

    assign timeout = (cycles_q >= LAST_CYCLE);
    assign cycles  = cycles_q;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        riscv_test_chan #(
            .ADDR_W      (ADDR_W),
            .XLEN        (XLEN),
            .TOHOST_ADDR (TOHOST_ADDR),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en[i]),
            .wr_addr  (wr_addr[i*ADDR_W +: ADDR_W]),
            .wr_data  (wr_data[i*XLEN +: XLEN]),
            .timeout  (timeout),
`ifdef RISCV_TEST_MONITOR_RETIRE_EN
            .retire   (retire[i]),
            .retired  (retired[i*CNT_W +: CNT_W]),
`endif
            .status   (chan_st[i]),
            .fail_num (fail_num[i*(XLEN-1) +: (XLEN-1)])
        );

        assign status[i*2 +: 2] = chan_st[i];
    end

`ifndef RISCV_TEST_MONITOR_RETIRE_EN
    logic unused_retire;
    assign unused_retire = ^retire;
`endif

    always_comb begin
        done     = 1'b1;
        all_pass = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (chan_st[i] == ST_RUN)  done     = 1'b0;
            if (chan_st[i] != ST_PASS) all_pass = 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench: a single-channel monitor driven from a vector table and a
// four-channel monitor exercised with hand-written multi-cycle sequences.
module tb_riscv_test_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // single-channel DUT
    logic         rst1 = 1'b0;
    logic         en1 = 1'b0;
    logic [15:0]  addr1 = '0;
    logic [31:0]  data1 = '0;
    logic         ret1 = 1'b0;
    logic [1:0]   status1;
    logic [30:0]  fail1;
    logic         done1, ap1;
    logic [31:0]  cyc1;
`ifdef RISCV_TEST_MONITOR_RETIRE_EN
    logic [31:0]  retd1;
`endif

    // four-channel DUT
    logic         rst4 = 1'b0;
    logic [3:0]   en4 = '0;
    logic [63:0]  addr4 = '0;
    logic [127:0] data4 = '0;
    logic [3:0]   ret4 = '0;
    logic [7:0]   status4;
    logic [123:0] fail4;
    logic         done4, ap4;
    logic [31:0]  cyc4;
`ifdef RISCV_TEST_MONITOR_RETIRE_EN
    logic [127:0] retd4;
`endif

    riscv_test_monitor #(
        .NCH     (1),
        .TIMEOUT (50)
    ) u_one (
        .clk      (clk),
        .rst      (rst1),
        .wr_en    (en1),
        .wr_addr  (addr1),
        .wr_data  (data1),
        .retire   (ret1),
        .status   (status1),
        .fail_num (fail1),
        .done     (done1),
        .all_pass (ap1),
        .cycles   (cyc1)
`ifdef RISCV_TEST_MONITOR_RETIRE_EN
       ,.retired  (retd1)
`endif
    );

    riscv_test_monitor #(
        .NCH     (4),
        .TIMEOUT (50)
    ) u_quad (
        .clk      (clk),
        .rst      (rst4),
        .wr_en    (en4),
        .wr_addr  (addr4),
        .wr_data  (data4),
        .retire   (ret4),
        .status   (status4),
        .fail_num (fail4),
        .done     (done4),
        .all_pass (ap4),
        .cycles   (cyc4)
`ifdef RISCV_TEST_MONITOR_RETIRE_EN
       ,.retired  (retd4)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;
    int bcyc    = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // one clock: inputs set before the rising edge, outputs sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        bcyc++;
    endtask

    task automatic reset1();
        rst1 = 1'b0;
        #2;
        rst1 = 1'b1;
        bcyc = 0;
    endtask

    task automatic reset4();
        rst4 = 1'b0;
        #2;
        rst4 = 1'b1;
        bcyc = 0;
    endtask

    task automatic wr4(input int ch, input logic [31:0] d);
        en4[ch]           = 1'b1;
        addr4[ch*16 +: 16] = 16'h1000;
        data4[ch*32 +: 32] = d;
    endtask

    task automatic run_to(input int n);
        while (bcyc < n) tick();
    endtask

    typedef struct {
        bit          rst;
        bit          en;
        logic [15:0] addr;
        logic [31:0] data;
        logic [1:0]  st;
        logic [30:0] fn;
        bit          dn;
        bit          ap;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 16'h1000, 32'h0000_0000, 2'd0, 31'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 16'h1000, 32'h0000_0002, 2'd0, 31'h0,        1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 16'h1004, 32'h0000_0001, 2'd0, 31'h0,        1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 16'h1000, 32'h0000_0001, 2'd0, 31'h0,        1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 16'h1000, 32'h0000_0001, 2'd1, 31'h0,        1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 16'h1000, 32'h0000_0007, 2'd1, 31'h0,        1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 16'h1000, 32'h0000_0007, 2'd2, 31'h3,        1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 16'h1000, 32'h0000_0001, 2'd2, 31'h3,        1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 16'h1000, 32'hFFFF_FFFF, 2'd2, 31'h7FFF_FFFF, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 16'h1000, 32'h8000_0001, 2'd2, 31'h4000_0000, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 16'h1000, 32'h0000_0003, 2'd2, 31'h1,        1'b1, 1'b0};

        // reset values while reset is held
        #1;
        chk("rst status1", status1, 0);
        chk("rst done1", done1, 0);
        chk("rst all_pass1", ap1, 0);
        chk("rst cycles1", cyc1, 0);
        chk("rst status4", status4, 0);
        chk("rst fail4", fail4, 0);
        @(negedge clk);
        rst4 = 1'b1;

        // table-driven single-channel decode
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].rst) reset1();
            en1   = vecs[i].en;
            addr1 = vecs[i].addr;
            data1 = vecs[i].data;
            tick();
            en1 = 1'b0;
            chk($sformatf("vec%0d status", i), status1, vecs[i].st);
            chk($sformatf("vec%0d fail_num", i), fail1, vecs[i].fn);
            chk($sformatf("vec%0d done", i), done1, vecs[i].dn);
            chk($sformatf("vec%0d all_pass", i), ap1, vecs[i].ap);
        end

        // single-channel pass at cycle 20, cycle counter freezes at 21
        reset1();
        run_to(20);
        chk("pass20 cycles before", cyc1, 20);
        chk("pass20 done before", done1, 0);
        en1 = 1'b1; addr1 = 16'h1000; data1 = 32'h1;
        tick();
        en1 = 1'b0;
        chk("pass20 status", status1, 1);
        chk("pass20 done", done1, 1);
        chk("pass20 all_pass", ap1, 1);
        chk("pass20 cycles", cyc1, 21);
        run_to(26);
        chk("pass20 cycles frozen", cyc1, 21);

        // retire counting, then asynchronous reset while in PASS
        reset1();
        ret1 = 1'b1;
        run_to(12);
        ret1 = 1'b0;
        en1 = 1'b1; addr1 = 16'h1000; data1 = 32'h1;
        tick();
        en1 = 1'b0;
        ret1 = 1'b1;
        run_to(16);
        ret1 = 1'b0;
        chk("retire status", status1, 1);
`ifdef RISCV_TEST_MONITOR_RETIRE_EN
        chk("retired frozen", retd1, 12);
`endif
        #2;
        rst1 = 1'b0;
        #1;
        chk("async status1", status1, 0);
        chk("async done1", done1, 0);
        chk("async all_pass1", ap1, 0);
        chk("async cycles1", cyc1, 0);
`ifdef RISCV_TEST_MONITOR_RETIRE_EN
        chk("async retired1", retd1, 0);
`endif
        @(negedge clk);
        rst1 = 1'b1;

        // watchdog race: ch0 hit on the timeout edge wins, others time out
        @(negedge clk);
        reset4();
        run_to(49);
        chk("race cycles49", cyc4, 49);
        chk("race status before", status4, 8'h00);
        chk("race done before", done4, 0);
        wr4(0, 32'h1);
        tick();
        en4 = '0;
        chk("race status", status4, 8'hFD);
        chk("race done", done4, 1);
        chk("race all_pass", ap4, 0);
        chk("race cycles", cyc4, 50);
        run_to(53);
        chk("race cycles frozen", cyc4, 50);

        // multi-channel ordering
        reset4();
        run_to(10);
        wr4(0, 32'h1);
        tick();
        en4 = '0;
        chk("order ch0 status", status4, 8'h01);
        run_to(30);
        wr4(1, 32'h1);
        wr4(2, 32'h1);
        tick();
        en4 = '0;
        chk("order three pass", status4, 8'h15);
        chk("order done early", done4, 0);
        run_to(40);
        wr4(3, 32'h5);
        tick();
        en4 = '0;
        chk("order final status", status4, 8'h95);
        chk("order ch3 fail_num", fail4[93 +: 31], 2);
        chk("order done", done4, 1);
        chk("order all_pass", ap4, 0);
        chk("order cycles", cyc4, 41);

        // asynchronous reset clears fail_num and status without a clock edge
        #2;
        rst4 = 1'b0;
        #1;
        chk("async status4", status4, 0);
        chk("async fail4", fail4, 0);
        chk("async done4", done4, 0);
        chk("async cycles4", cyc4, 0);
        @(negedge clk);
        rst4 = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
